// File: rtl/tick_timer_if.sv
// Peripheral bus bundle for the tick timer.
// The CPU side drives the strobes; the timer returns read data and irq.
interface tick_timer_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       i_addr;
  logic             i_we;
  logic             i_re;
  logic [WIDTH-1:0] i_wdata;
  logic [WIDTH-1:0] o_rdata;
  logic             o_irq;

  modport master (
    output i_addr, i_we, i_re, i_wdata,
    input  o_rdata, o_irq
  );

  modport slave (
    input  i_addr, i_we, i_re, i_wdata,
    output o_rdata, o_irq
  );
endinterface

// File: rtl/tick_timer.sv
// Down-counting timer peripheral with one-shot/auto-reload modes,
// a sticky expiry flag and a level interrupt.
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  tick_timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_RELOAD = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_e           state_q;
  logic             auto_q;
  logic             irqen_q;
  logic             exp_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  logic wr_ctrl;
  logic wr_reload;
  logic wr_count;
  logic wr_status;
  logic tick;
  logic expire;

  assign wr_ctrl   = bus.i_we && (bus.i_addr == A_CTRL);
  assign wr_reload = bus.i_we && (bus.i_addr == A_RELOAD);
  assign wr_count  = bus.i_we && (bus.i_addr == A_COUNT);
  assign wr_status = bus.i_we && (bus.i_addr == A_STATUS);

  assign tick   = i_ce && (state_q == RUN);
  assign expire = tick && (count_q == '0);

  always_comb begin
    rdata_d = '0;
    case (bus.i_addr)
      A_CTRL: begin
        rdata_d[0] = (state_q == RUN);
        rdata_d[1] = auto_q;
        rdata_d[2] = irqen_q;
      end
      A_RELOAD: rdata_d = reload_q;
      A_COUNT:  rdata_d = count_q;
      default:  rdata_d[0] = exp_q;
    endcase
  end

  // Later assignments win: expiry beats STATUS clear,
  // and bus writes beat the tick update of COUNT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      auto_q   <= 1'b0;
      irqen_q  <= 1'b0;
      exp_q    <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (bus.i_re)
        rdata_q <= rdata_d;
      if (wr_status && bus.i_wdata[0])
        exp_q <= 1'b0;
      if (tick) begin
        if (expire) begin
          exp_q <= 1'b1;
          if (auto_q)
            count_q <= reload_q;
          else
            state_q <= IDLE;
        end else begin
          count_q <= count_q - 1'b1;
        end
      end
      if (wr_reload)
        reload_q <= bus.i_wdata;
      if (wr_ctrl) begin
        auto_q  <= bus.i_wdata[1];
        irqen_q <= bus.i_wdata[2];
        if (!bus.i_wdata[0]) begin
          state_q <= IDLE;
          count_q <= count_q;
        end else if (state_q == IDLE) begin
          state_q <= RUN;
          count_q <= reload_q;
        end
      end
      if (wr_count)
        count_q <= bus.i_wdata;
    end
  end

  assign bus.o_rdata = rdata_q;
  assign bus.o_irq   = exp_q & irqen_q;
endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer.
// Expected values are hand-computed per step.
module tb_tick_timer;
  localparam int W = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_ce  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] rv;

  tick_timer_if #(.WIDTH(W)) bus ();

  tick_timer #(.WIDTH(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ce  (i_ce),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] a, input logic we,
                     input logic re, input logic [W-1:0] d,
                     input logic ce);
    bus.i_addr  = a;
    bus.i_we    = we;
    bus.i_re    = re;
    bus.i_wdata = d;
    i_ce        = ce;
    @(posedge i_clk);
    #1;
    bus.i_we = 1'b0;
    bus.i_re = 1'b0;
    i_ce     = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    cyc(a, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [W-1:0] v);
    cyc(a, 1'b0, 1'b1, '0, 1'b0);
    v = bus.o_rdata;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      cyc(2'd0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    bus.i_addr  = 2'd0;
    bus.i_we    = 1'b0;
    bus.i_re    = 1'b0;
    bus.i_wdata = '0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // reset values
    chk("rst_rdata", bus.o_rdata, 16'h0);
    chk("rst_irq", {15'h0, bus.o_irq}, 16'h0);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], rv);
      chk($sformatf("rst_reg%0d", a), rv, 16'h0);
    end

    // one-shot, RELOAD=3 expires on 4th tick
    wr(2'd1, 16'd3);
    wr(2'd0, 16'h1);
    ticks(3);
    rd(2'd3, rv); chk("os_exp_early", rv, 16'h0);
    rd(2'd2, rv); chk("os_cnt_3t", rv, 16'h0);
    ticks(1);
    rd(2'd3, rv); chk("os_exp", rv, 16'h1);
    rd(2'd0, rv); chk("os_ctrl", rv, 16'h0);
    rd(2'd2, rv); chk("os_cnt", rv, 16'h0);
    ticks(2);
    rd(2'd2, rv); chk("idle_ce_ign", rv, 16'h0);
    wr(2'd3, 16'h1);
    rd(2'd3, rv); chk("os_clr", rv, 16'h0);

    // auto-reload with irq, RELOAD=2
    wr(2'd1, 16'd2);
    wr(2'd0, 16'h7);
    rd(2'd2, rv); chk("ar_start", rv, 16'd2);
    ticks(2);
    chk("ar_irq_lo", {15'h0, bus.o_irq}, 16'h0);
    ticks(1);
    chk("ar_irq_hi", {15'h0, bus.o_irq}, 16'h1);
    rd(2'd2, rv); chk("ar_cnt1", rv, 16'd2);
    ticks(3);
    rd(2'd2, rv); chk("ar_cnt2", rv, 16'd2);
    ticks(3);
    rd(2'd2, rv); chk("ar_cnt3", rv, 16'd2);
    rd(2'd0, rv); chk("ar_ctrl", rv, 16'h7);
    chk("ar_irq_hold", {15'h0, bus.o_irq}, 16'h1);
    wr(2'd3, 16'h0);
    chk("ar_w0_noclr", {15'h0, bus.o_irq}, 16'h1);
    wr(2'd3, 16'h1);
    chk("ar_irq_clr", {15'h0, bus.o_irq}, 16'h0);
    ticks(1);
    wr(2'd0, 16'h0);
    ticks(2);
    rd(2'd2, rv); chk("stop_hold", rv, 16'd1);

    // COUNT write on tick cycle, with same-cycle read of old value
    wr(2'd1, 16'd9);
    wr(2'd0, 16'h1);
    cyc(2'd2, 1'b1, 1'b1, 16'd5, 1'b1);
    chk("rw_old", bus.o_rdata, 16'd9);
    rd(2'd2, rv); chk("cw_wins", rv, 16'd5);
    ticks(1);
    rd(2'd2, rv); chk("cw_dec", rv, 16'd4);

    // STATUS clear on the expiry cycle: set wins
    wr(2'd2, 16'd0);
    cyc(2'd3, 1'b1, 1'b0, 16'h1, 1'b1);
    rd(2'd3, rv); chk("clr_vs_exp", rv, 16'h1);
    rd(2'd0, rv); chk("clr_ctrl", rv, 16'h0);
    chk("clr_noirq", {15'h0, bus.o_irq}, 16'h0);
    wr(2'd3, 16'h1);

    // RELOAD=0 auto: expires every tick
    wr(2'd1, 16'd0);
    wr(2'd0, 16'h7);
    ticks(1);
    chk("r0_irq", {15'h0, bus.o_irq}, 16'h1);
    rd(2'd2, rv); chk("r0_cnt", rv, 16'd0);

    // reset mid-count
    wr(2'd1, 16'd7);
    wr(2'd2, 16'd7);
    rd(2'd2, rv); chk("pre_rst_cnt", rv, 16'd7);
    chk("pre_rst_irq", {15'h0, bus.o_irq}, 16'h1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("mr_irq", {15'h0, bus.o_irq}, 16'h0);
    chk("mr_rdata", bus.o_rdata, 16'h0);
    ticks(3);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], rv);
      chk($sformatf("mr_reg%0d", a), rv, 16'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
